// File: rtl/store_port_arbiter_if.sv
// Store request/response bundle: CPU and bridge request channels plus the registered DM write port.
// The slave modport is the arbiter's view; master is the requester/memory side.
interface store_port_arbiter_if;
    logic        c_valid;
    logic [2:0]  c_op;
    logic [31:0] c_addr;
    logic [31:0] c_wd;
    logic        c_ready;

    logic        b_valid;
    logic [2:0]  b_op;
    logic [31:0] b_addr;
    logic [31:0] b_wd;
    logic        b_ready;

    logic        dm_ready;
    logic        dm_we;
    logic [31:0] dm_addr;
    logic [3:0]  dm_byteen;
    logic [31:0] dm_wdata;
    logic        err_align;
    logic        grant_b;

    modport slave (
        input  c_valid, c_op, c_addr, c_wd,
        input  b_valid, b_op, b_addr, b_wd,
        input  dm_ready,
        output c_ready, b_ready,
        output dm_we, dm_addr, dm_byteen, dm_wdata, err_align, grant_b
    );

    modport master (
        output c_valid, c_op, c_addr, c_wd,
        output b_valid, b_op, b_addr, b_wd,
        output dm_ready,
        input  c_ready, b_ready,
        input  dm_we, dm_addr, dm_byteen, dm_wdata, err_align, grant_b
    );
endinterface

// File: rtl/store_port_arbiter.sv
// Round-robin arbiter of CPU and bridge stores onto one DM write port; accept at N, dm_we from N+1.
// Requests are held off (ready low) while a write waits in HOLD for dm_ready; at most one write per 2 cycles.
module store_port_arbiter (
    input  logic                 clk,
    input  logic                 reset,
    store_port_arbiter_if.slave  bus
);
    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } state_e;

    state_e      state_q, state_d;
    logic        last_grant_q, last_grant_d;
    logic        dm_we_q, dm_we_d;
    logic [31:0] dm_addr_q, dm_addr_d;
    logic [3:0]  dm_byteen_q, dm_byteen_d;
    logic [31:0] dm_wdata_q, dm_wdata_d;
    logic        err_align_q, err_align_d;
    logic        grant_b_q, grant_b_d;

    logic        pick_b;
    logic [2:0]  sel_op;
    logic [31:0] sel_addr;
    logic [31:0] sel_wd;
    logic        legal;
    logic [3:0]  lane_be;
    logic [31:0] lane_wd;
    logic        c_rdy;
    logic        b_rdy;

    // On a tie the bridge wins only when the CPU took the previous acceptance.
    always_comb begin
        pick_b   = bus.b_valid && (!bus.c_valid || !last_grant_q);
        sel_op   = pick_b ? bus.b_op   : bus.c_op;
        sel_addr = pick_b ? bus.b_addr : bus.c_addr;
        sel_wd   = pick_b ? bus.b_wd   : bus.c_wd;
    end

    always_comb begin
        legal   = 1'b0;
        lane_be = 4'b0000;
        lane_wd = 32'h0;
        case (sel_op)
            3'd1: begin
                legal   = (sel_addr[1:0] == 2'b00);
                lane_be = 4'b1111;
                lane_wd = sel_wd;
            end
            3'd2: begin
                legal = !sel_addr[0];
                if (sel_addr[1]) begin
                    lane_be = 4'b1100;
                    lane_wd = {sel_wd[15:0], 16'h0};
                end else begin
                    lane_be = 4'b0011;
                    lane_wd = {16'h0, sel_wd[15:0]};
                end
            end
            3'd3: begin
                legal = 1'b1;
                case (sel_addr[1:0])
                    2'd0:    begin lane_be = 4'b0001; lane_wd = {24'h0, sel_wd[7:0]};        end
                    2'd1:    begin lane_be = 4'b0010; lane_wd = {16'h0, sel_wd[7:0], 8'h0};  end
                    2'd2:    begin lane_be = 4'b0100; lane_wd = {8'h0, sel_wd[7:0], 16'h0};  end
                    default: begin lane_be = 4'b1000; lane_wd = {sel_wd[7:0], 24'h0};        end
                endcase
            end
            default: legal = 1'b0;
        endcase
    end

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        dm_we_d      = dm_we_q;
        dm_addr_d    = dm_addr_q;
        dm_byteen_d  = dm_byteen_q;
        dm_wdata_d   = dm_wdata_q;
        grant_b_d    = grant_b_q;
        err_align_d  = 1'b0;
        c_rdy        = 1'b0;
        b_rdy        = 1'b0;
        case (state_q)
            IDLE: begin
                dm_we_d = 1'b0;
                // Ready is gated by reset so nothing is handed off while reset is held.
                if (reset && (bus.c_valid || bus.b_valid)) begin
                    c_rdy        = !pick_b;
                    b_rdy        = pick_b;
                    last_grant_d = pick_b;
                    if (legal) begin
                        state_d     = HOLD;
                        dm_we_d     = 1'b1;
                        dm_addr_d   = {sel_addr[31:2], 2'b00};
                        dm_byteen_d = lane_be;
                        dm_wdata_d  = lane_wd;
                        grant_b_d   = pick_b;
                    end else begin
                        err_align_d = 1'b1;
                    end
                end
            end
            HOLD: begin
                if (bus.dm_ready) begin
                    state_d = IDLE;
                    dm_we_d = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q      <= IDLE;
            last_grant_q <= 1'b1;
            dm_we_q      <= 1'b0;
            dm_addr_q    <= 32'h0;
            dm_byteen_q  <= 4'b0000;
            dm_wdata_q   <= 32'h0;
            err_align_q  <= 1'b0;
            grant_b_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            dm_we_q      <= dm_we_d;
            dm_addr_q    <= dm_addr_d;
            dm_byteen_q  <= dm_byteen_d;
            dm_wdata_q   <= dm_wdata_d;
            err_align_q  <= err_align_d;
            grant_b_q    <= grant_b_d;
        end
    end

    assign bus.c_ready   = c_rdy;
    assign bus.b_ready   = b_rdy;
    assign bus.dm_we     = dm_we_q;
    assign bus.dm_addr   = dm_addr_q;
    assign bus.dm_byteen = dm_byteen_q;
    assign bus.dm_wdata  = dm_wdata_q;
    assign bus.err_align = err_align_q;
    assign bus.grant_b   = grant_b_q;
endmodule

// File: tb/tb_store_port_arbiter.sv
// Directed scenarios followed by a randomized run against a transaction-level reference model.
module tb_store_port_arbiter;
    logic clk;
    logic reset;
    int   checks;
    int   failures;

    store_port_arbiter_if sif ();

    store_port_arbiter dut (
        .clk   (clk),
        .reset (reset),
        .bus   (sif.slave)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog simulation time limit expired");
        $fatal(1, "timeout");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_c(input logic v, input logic [2:0] op, input logic [31:0] a, input logic [31:0] wd);
        sif.c_valid = v; sif.c_op = op; sif.c_addr = a; sif.c_wd = wd;
    endtask

    task automatic set_b(input logic v, input logic [2:0] op, input logic [31:0] a, input logic [31:0] wd);
        sif.b_valid = v; sif.b_op = op; sif.b_addr = a; sif.b_wd = wd;
    endtask

    task automatic do_reset();
        set_c(1'b0, 3'd0, 32'h0, 32'h0);
        set_b(1'b0, 3'd0, 32'h0, 32'h0);
        sif.dm_ready = 1'b1;
        reset = 1'b0;
        tick();
        tick();
        reset = 1'b1;
    endtask

    // Lane placement from the store rules: shift the element into the addressed byte position.
    function automatic void ref_lanes(input logic [2:0] op, input logic [31:0] a, input logic [31:0] wd,
                                      output bit ok, output logic [3:0] be, output logic [31:0] wdata);
        int sh;
        sh = int'(a[1:0]);
        ok = 1'b0; be = 4'b0000; wdata = 32'h0;
        if (op == 3'd1) begin
            ok = (sh == 0); be = 4'b1111; wdata = wd;
        end else if (op == 3'd2) begin
            ok = (a[0] == 1'b0); be = 4'b0011 << sh; wdata = {16'h0, wd[15:0]} << (8 * sh);
        end else if (op == 3'd3) begin
            ok = 1'b1; be = 4'b0001 << sh; wdata = {24'h0, wd[7:0]} << (8 * sh);
        end
    endfunction

    task automatic test_reset();
        reset = 1'b0;
        sif.dm_ready = 1'b1;
        set_c(1'b1, 3'd1, 32'h10, 32'h11111111);
        set_b(1'b1, 3'd1, 32'h20, 32'h22222222);
        tick();
        tick();
        checks++; if (sif.c_ready !== 1'b0) begin failures++; $display("FAIL rst_c_ready got=%b exp=0", sif.c_ready); end
        checks++; if (sif.b_ready !== 1'b0) begin failures++; $display("FAIL rst_b_ready got=%b exp=0", sif.b_ready); end
        checks++; if (sif.dm_we !== 1'b0) begin failures++; $display("FAIL rst_dm_we got=%b exp=0", sif.dm_we); end
        checks++; if (sif.dm_addr !== 32'h0) begin failures++; $display("FAIL rst_dm_addr got=%h exp=0", sif.dm_addr); end
        checks++; if (sif.dm_byteen !== 4'h0) begin failures++; $display("FAIL rst_dm_byteen got=%h exp=0", sif.dm_byteen); end
        checks++; if (sif.dm_wdata !== 32'h0) begin failures++; $display("FAIL rst_dm_wdata got=%h exp=0", sif.dm_wdata); end
        checks++; if (sif.err_align !== 1'b0) begin failures++; $display("FAIL rst_err_align got=%b exp=0", sif.err_align); end
        checks++; if (sif.grant_b !== 1'b0) begin failures++; $display("FAIL rst_grant_b got=%b exp=0", sif.grant_b); end
        set_c(1'b0, 3'd0, 32'h0, 32'h0);
        set_b(1'b0, 3'd0, 32'h0, 32'h0);
        reset = 1'b1;
        tick();
    endtask

    task automatic test_word();
        do_reset();
        set_c(1'b1, 3'd1, 32'h10, 32'hAABBCCDD);
        #1;
        checks++; if (sif.c_ready !== 1'b1) begin failures++; $display("FAIL word_c_ready got=%b exp=1", sif.c_ready); end
        checks++; if (sif.dm_we !== 1'b0) begin failures++; $display("FAIL word_we_before got=%b exp=0", sif.dm_we); end
        tick();
        set_c(1'b0, 3'd0, 32'h0, 32'h0);
        checks++; if (sif.dm_we !== 1'b1) begin failures++; $display("FAIL word_dm_we got=%b exp=1", sif.dm_we); end
        checks++; if (sif.dm_addr !== 32'h10) begin failures++; $display("FAIL word_dm_addr got=%h exp=00000010", sif.dm_addr); end
        checks++; if (sif.dm_byteen !== 4'b1111) begin failures++; $display("FAIL word_byteen got=%b exp=1111", sif.dm_byteen); end
        checks++; if (sif.dm_wdata !== 32'hAABBCCDD) begin failures++; $display("FAIL word_wdata got=%h exp=aabbccdd", sif.dm_wdata); end
        checks++; if (sif.grant_b !== 1'b0) begin failures++; $display("FAIL word_grant_b got=%b exp=0", sif.grant_b); end
        tick();
        checks++; if (sif.dm_we !== 1'b0) begin failures++; $display("FAIL word_we_after got=%b exp=0", sif.dm_we); end
    endtask

    task automatic test_lanes();
        do_reset();
        set_c(1'b1, 3'd3, 32'h13, 32'h000000EE);
        tick();
        set_c(1'b0, 3'd0, 32'h0, 32'h0);
        checks++; if (sif.dm_addr !== 32'h10) begin failures++; $display("FAIL byte_addr got=%h exp=00000010", sif.dm_addr); end
        checks++; if (sif.dm_byteen !== 4'b1000) begin failures++; $display("FAIL byte_byteen got=%b exp=1000", sif.dm_byteen); end
        checks++; if (sif.dm_wdata !== 32'hEE000000) begin failures++; $display("FAIL byte_wdata got=%h exp=ee000000", sif.dm_wdata); end
        tick();
        set_b(1'b1, 3'd2, 32'h22, 32'h00001234);
        tick();
        set_b(1'b0, 3'd0, 32'h0, 32'h0);
        checks++; if (sif.dm_addr !== 32'h20) begin failures++; $display("FAIL half_addr got=%h exp=00000020", sif.dm_addr); end
        checks++; if (sif.dm_byteen !== 4'b1100) begin failures++; $display("FAIL half_byteen got=%b exp=1100", sif.dm_byteen); end
        checks++; if (sif.dm_wdata !== 32'h12340000) begin failures++; $display("FAIL half_wdata got=%h exp=12340000", sif.dm_wdata); end
        checks++; if (sif.grant_b !== 1'b1) begin failures++; $display("FAIL half_grant_b got=%b exp=1", sif.grant_b); end
        tick();
    endtask

    task automatic test_round_robin();
        logic exp_b;
        do_reset();
        set_c(1'b1, 3'd1, 32'h100, 32'hC0C0C0C0);
        set_b(1'b1, 3'd1, 32'h200, 32'hB0B0B0B0);
        for (int i = 0; i < 4; i++) begin
            exp_b = (i % 2 == 1);
            #1;
            checks++; if (sif.c_ready !== !exp_b || sif.b_ready !== exp_b) begin
                failures++; $display("FAIL rr_ready[%0d] got c=%b b=%b exp c=%b b=%b", i, sif.c_ready, sif.b_ready, !exp_b, exp_b);
            end
            tick();
            checks++; if (sif.dm_we !== 1'b1 || sif.grant_b !== exp_b) begin
                failures++; $display("FAIL rr_grant[%0d] got we=%b grant_b=%b exp we=1 grant_b=%b", i, sif.dm_we, sif.grant_b, exp_b);
            end
            checks++; if (sif.dm_addr !== (exp_b ? 32'h200 : 32'h100)) begin
                failures++; $display("FAIL rr_addr[%0d] got=%h exp=%h", i, sif.dm_addr, exp_b ? 32'h200 : 32'h100);
            end
            tick();
        end
        set_c(1'b0, 3'd0, 32'h0, 32'h0);
        set_b(1'b0, 3'd0, 32'h0, 32'h0);
        tick();
    endtask

    task automatic test_misaligned();
        do_reset();
        set_c(1'b1, 3'd1, 32'h05, 32'h55555555);
        #1;
        checks++; if (sif.c_ready !== 1'b1) begin failures++; $display("FAIL mis_c_ready got=%b exp=1", sif.c_ready); end
        tick();
        set_c(1'b0, 3'd0, 32'h0, 32'h0);
        checks++; if (sif.dm_we !== 1'b0) begin failures++; $display("FAIL mis_dm_we got=%b exp=0", sif.dm_we); end
        checks++; if (sif.err_align !== 1'b1) begin failures++; $display("FAIL mis_err_pulse got=%b exp=1", sif.err_align); end
        tick();
        checks++; if (sif.err_align !== 1'b0) begin failures++; $display("FAIL mis_err_clear got=%b exp=0", sif.err_align); end
        checks++; if (sif.dm_we !== 1'b0) begin failures++; $display("FAIL mis_dm_we2 got=%b exp=0", sif.dm_we); end
    endtask

    task automatic test_hold_stall();
        do_reset();
        sif.dm_ready = 1'b0;
        set_c(1'b1, 3'd2, 32'h40, 32'h0000BEEF);
        tick();
        set_c(1'b1, 3'd1, 32'h80, 32'h12345678);
        set_b(1'b1, 3'd3, 32'h91, 32'h000000AA);
        for (int k = 0; k < 4; k++) begin
            if (k == 3) sif.dm_ready = 1'b1;
            #1;
            checks++; if (sif.c_ready !== 1'b0 || sif.b_ready !== 1'b0) begin
                failures++; $display("FAIL hold_ready[%0d] got c=%b b=%b exp 0 0", k, sif.c_ready, sif.b_ready);
            end
            checks++; if (sif.dm_we !== 1'b1 || sif.dm_addr !== 32'h40 || sif.dm_byteen !== 4'b0011 || sif.dm_wdata !== 32'h0000BEEF) begin
                failures++; $display("FAIL hold_stable[%0d] got we=%b addr=%h be=%b wd=%h exp 1 00000040 0011 0000beef",
                                     k, sif.dm_we, sif.dm_addr, sif.dm_byteen, sif.dm_wdata);
            end
            if (k == 3) begin
                set_c(1'b0, 3'd0, 32'h0, 32'h0);
                set_b(1'b0, 3'd0, 32'h0, 32'h0);
            end
            tick();
        end
        checks++; if (sif.dm_we !== 1'b0) begin failures++; $display("FAIL hold_release got we=%b exp=0", sif.dm_we); end
    endtask

    task automatic test_reset_in_hold();
        do_reset();
        sif.dm_ready = 1'b0;
        set_b(1'b1, 3'd1, 32'h80, 32'hDEADBEEF);
        #1;
        checks++; if (sif.b_ready !== 1'b1) begin failures++; $display("FAIL rih_b_ready got=%b exp=1", sif.b_ready); end
        tick();
        checks++; if (sif.dm_we !== 1'b1 || sif.grant_b !== 1'b1) begin
            failures++; $display("FAIL rih_hold got we=%b grant_b=%b exp 1 1", sif.dm_we, sif.grant_b);
        end
        reset = 1'b0;
        set_c(1'b1, 3'd1, 32'h90, 32'h0BADF00D);
        #1;
        checks++; if (sif.c_ready !== 1'b0 || sif.b_ready !== 1'b0) begin
            failures++; $display("FAIL rih_ready_in_reset got c=%b b=%b exp 0 0", sif.c_ready, sif.b_ready);
        end
        tick();
        checks++; if (sif.dm_we !== 1'b0 || sif.dm_addr !== 32'h0 || sif.dm_byteen !== 4'h0 || sif.dm_wdata !== 32'h0
                      || sif.grant_b !== 1'b0 || sif.err_align !== 1'b0) begin
            failures++; $display("FAIL rih_cleared got we=%b addr=%h be=%b wd=%h gb=%b err=%b exp all zero",
                                 sif.dm_we, sif.dm_addr, sif.dm_byteen, sif.dm_wdata, sif.grant_b, sif.err_align);
        end
        reset = 1'b1;
        sif.dm_ready = 1'b1;
        #1;
        checks++; if (sif.c_ready !== 1'b1 || sif.b_ready !== 1'b0) begin
            failures++; $display("FAIL rih_tie_cpu got c=%b b=%b exp 1 0", sif.c_ready, sif.b_ready);
        end
        tick();
        set_c(1'b0, 3'd0, 32'h0, 32'h0);
        set_b(1'b0, 3'd0, 32'h0, 32'h0);
        checks++; if (sif.dm_we !== 1'b1 || sif.grant_b !== 1'b0 || sif.dm_addr !== 32'h90) begin
            failures++; $display("FAIL rih_after got we=%b gb=%b addr=%h exp 1 0 00000090", sif.dm_we, sif.grant_b, sif.dm_addr);
        end
        tick();
    endtask

    task automatic test_random();
        bit          m_busy, m_last, m_err, m_gb, exp_c, exp_b, ok;
        logic [31:0] m_addr, m_wdata, a, wd, w;
        logic [3:0]  m_be, be;
        logic [2:0]  op;
        do_reset();
        m_busy = 0; m_last = 1; m_err = 0; m_gb = 0;
        m_addr = 0; m_wdata = 0; m_be = 0;
        for (int n = 0; n < 600; n++) begin
            set_c($urandom_range(0, 9) < 7, 3'($urandom_range(0, 4)), $urandom, $urandom);
            set_b($urandom_range(0, 9) < 7, 3'($urandom_range(0, 4)), $urandom, $urandom);
            sif.dm_ready = $urandom_range(0, 9) < 6;
            #1;
            exp_c = 0; exp_b = 0;
            if (!m_busy && (sif.c_valid || sif.b_valid)) begin
                exp_b = (sif.c_valid && sif.b_valid) ? !m_last : sif.b_valid;
                exp_c = !exp_b;
            end
            checks++; if (sif.c_ready !== exp_c || sif.b_ready !== exp_b) begin
                failures++; $display("FAIL rnd_ready[%0d] got c=%b b=%b exp c=%b b=%b", n, sif.c_ready, sif.b_ready, exp_c, exp_b);
            end
            m_err = 0;
            if (m_busy) begin
                if (sif.dm_ready) m_busy = 0;
            end else if (exp_c || exp_b) begin
                op = exp_b ? sif.b_op : sif.c_op;
                a  = exp_b ? sif.b_addr : sif.c_addr;
                wd = exp_b ? sif.b_wd : sif.c_wd;
                ref_lanes(op, a, wd, ok, be, w);
                m_last = exp_b;
                if (ok) begin
                    m_busy = 1; m_addr = a & ~32'h3; m_be = be; m_wdata = w; m_gb = exp_b;
                end else begin
                    m_err = 1;
                end
            end
            tick();
            checks++; if (sif.dm_we !== m_busy || sif.err_align !== m_err) begin
                failures++; $display("FAIL rnd_status[%0d] got we=%b err=%b exp we=%b err=%b", n, sif.dm_we, sif.err_align, m_busy, m_err);
            end
            if (m_busy) begin
                checks++; if (sif.dm_addr !== m_addr || sif.dm_byteen !== m_be || sif.dm_wdata !== m_wdata || sif.grant_b !== m_gb) begin
                    failures++; $display("FAIL rnd_write[%0d] got addr=%h be=%b wd=%h gb=%b exp addr=%h be=%b wd=%h gb=%b",
                                         n, sif.dm_addr, sif.dm_byteen, sif.dm_wdata, sif.grant_b, m_addr, m_be, m_wdata, m_gb);
                end
            end
        end
    endtask

    initial begin
        checks = 0;
        failures = 0;
        reset = 1'b0;
        sif.dm_ready = 1'b1;
        set_c(1'b0, 3'd0, 32'h0, 32'h0);
        set_b(1'b0, 3'd0, 32'h0, 32'h0);
        test_reset();
        test_word();
        test_lanes();
        test_round_robin();
        test_misaligned();
        test_hold_stall();
        test_reset_in_hold();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/store_port_arbiter.md
STORE_PORT_ARBITER -- requirements
Module: store_port_arbiter

Interface
REQ-001 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-002 SHALL have port reset  input  1  synchronous, active-low reset; sampled on rising clk only.
REQ-003 SHALL have ports c_valid, c_op[2:0], c_addr[31:0], c_wd[31:0]  input  CPU M-stage store request.
REQ-004 SHALL have port c_ready  output  1  CPU request accepted this cycle.
REQ-005 SHALL have ports b_valid, b_op[2:0], b_addr[31:0], b_wd[31:0]  input  bridge/debug store request.
REQ-006 SHALL have port b_ready  output  1  bridge request accepted this cycle.
REQ-007 SHALL have port dm_ready  input  1  data memory consumes the presented write this cycle.
REQ-008 SHALL have ports dm_we 1, dm_addr[31:0], dm_byteen[3:0], dm_wdata[31:0]  output  registered DM write port.
REQ-009 SHALL have port err_align  output  1  one-cycle pulse: accepted request was misaligned and dropped.
REQ-010 SHALL have port grant_b  output  1  requester of the write currently on dm_* (0 CPU, 1 bridge).

Function
REQ-011 SHALL decode op: 3'd1 word, 3'd2 halfword, 3'd3 byte; any other op is an illegal request, accepted and dropped with err_align pulse.
REQ-012 SHALL form lanes for word: byteen 1111, wdata = wd.
REQ-013 SHALL form lanes for halfword: addr[1]=0 -> 0011, {16'b0,wd[15:0]}; addr[1]=1 -> 1100, {wd[15:0],16'b0}.
REQ-014 SHALL form lanes for byte: addr[1:0]=n -> byteen bit n only; wd[7:0] placed at bits 8n+7:8n, other bits zero.
REQ-015 SHALL flag misaligned: word with addr[1:0]!=0, halfword with addr[0]=1; such request is accepted, not written, err_align pulses next cycle.
REQ-016 SHALL drive dm_addr = {addr[31:2],2'b00}.
REQ-017 SHALL implement FSM IDLE / HOLD.
- IDLE: dm_we=0; if any valid, arbitrate, assert chosen ready same cycle; legal request -> register dm_* and go HOLD; illegal -> stay IDLE.
- HOLD: dm_we=1, dm_* stable; both ready low; on dm_ready=1 -> IDLE next cycle.
REQ-018 SHALL arbitrate round-robin: last_grant register; when both valid, grant the side not granted last; single valid granted directly.
REQ-019 SHALL update last_grant only on acceptance (legal or illegal).
REQ-020 SHALL have latency: acceptance cycle N -> dm_we=1 from cycle N+1; minimum throughput one write per 2 cycles.
REQ-021 SHALL assert c_ready and b_ready combinationally from state, valids and last_grant; never both high.
REQ-022 SHALL hold request on requester side until ready; valid deasserted before ready causes no effect.
REQ-023 SHALL keep dm_* constant throughout HOLD regardless of input changes.

Reset
REQ-024 SHALL, when reset=0 at a clk edge, enter IDLE, clear dm_we, dm_addr, dm_byteen, dm_wdata, err_align, grant_b to 0 and set last_grant to bridge (CPU wins first tie).
REQ-025 SHALL abandon a HOLD write on reset without completing it; ready outputs low while reset=0.

Verification
REQ-026 SHALL cover: reset, c_valid=1 op=1 addr=0x10 wd=0xAABBCCDD -> c_ready same cycle, next cycle dm_we=1 addr=0x10 byteen=1111 wdata=0xAABBCCDD.
REQ-027 SHALL cover: byte store addr=0x13 wd=0x000000EE -> byteen=1000, wdata=0xEE000000; halfword addr=0x22 wd=0x1234 -> byteen=1100, wdata=0x12340000.
REQ-028 SHALL cover: both valid continuously after reset -> grants CPU, bridge, CPU, bridge; grant_b matches each dm write.
REQ-029 SHALL cover: word store addr=0x05 -> accepted, dm_we stays 0, err_align=1 for exactly one cycle.
REQ-030 SHALL cover: dm_ready=0 for 3 cycles in HOLD -> dm_* unchanged, both ready low; dm_ready=1 -> IDLE next cycle.
REQ-031 SHALL cover: reset=0 asserted during HOLD -> next cycle dm_we=0, all outputs zero, following tie granted to CPU.
